// File: rtl/shot_pkg.sv
// Shared types and constants for the shot sprite: bitmap geometry, life-cycle
// states and the signed coordinate type used for the bounding-box compare.
package shot_pkg;

  localparam int OBJECT_WIDTH_X  = 16;
  localparam int OBJECT_HEIGHT_Y = 16;
  localparam logic [7:0] TRANSPARENT_COLOR = 8'hFF;

  typedef enum logic [1:0] {IDLE, FLY, FLASH, DONE} shot_state_t;

  // Packed RGB332 bitmap, indexed [row][col][7:0] with row 0 at the top.
  typedef logic [OBJECT_HEIGHT_Y-1:0][OBJECT_WIDTH_X-1:0][7:0] shot_bitmap_t;

  typedef logic signed [11:0] coord_t;

  // True when an offset lies in [0, extent); signed so off-screen origins never wrap.
  function automatic logic in_range(input coord_t d, input coord_t extent);
    return (d >= 12'sd0) && (d < extent);
  endfunction

endpackage

// File: rtl/shot_flash_fsm.sv
// Shot life cycle: IDLE -> FLY -> FLASH -> DONE, with frame and blink counters
// advanced by start-of-frame ticks. All outputs are registered.
module shot_flash_fsm
  import shot_pkg::*;
#(
  parameter int FLASH_FRAMES = 16,
  parameter int BLINK_FRAMES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic fire,
  input  logic hit,
  output logic shotActive,
  output logic shotDone,
  output logic visible,
  output logic blinkOn
);

  localparam logic [7:0] FRAME_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  shot_state_t state_r, next_s;
  logic [7:0]  frame_cnt_r, blink_cnt_r;
  logic        blink_on_r, shot_active_r, shot_done_r;

  // Next-state decode; fire only matters in IDLE, hit only in FLY.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (fire) next_s = FLY;
        else      next_s = IDLE;
      end
      FLY: begin
        if (hit) next_s = FLASH;
        else     next_s = FLY;
      end
      FLASH: begin
        if (startOfFrame && (frame_cnt_r == FRAME_LAST)) next_s = DONE;
        else                                             next_s = FLASH;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register and registered status flags derived from the next state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= IDLE;
      shot_active_r <= 1'b0;
      shot_done_r   <= 1'b0;
    end else begin
      state_r       <= next_s;
      shot_active_r <= (next_s == FLY) || (next_s == FLASH);
      shot_done_r   <= (next_s == DONE);
    end
  end

  // Frame/blink counters; the tick coinciding with the hit is not counted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_r <= 8'd0;
      blink_cnt_r <= 8'd0;
      blink_on_r  <= 1'b0;
    end else if ((state_r == FLY) && hit) begin
      frame_cnt_r <= 8'd0;
      blink_cnt_r <= 8'd0;
      blink_on_r  <= 1'b1;
    end else if ((state_r == FLASH) && startOfFrame) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= 8'd0;
        blink_on_r  <= ~blink_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 8'd1;
      end
    end else if (state_r != FLASH) begin
      frame_cnt_r <= 8'd0;
      blink_cnt_r <= 8'd0;
      blink_on_r  <= 1'b0;
    end else begin
      frame_cnt_r <= frame_cnt_r;
      blink_cnt_r <= blink_cnt_r;
      blink_on_r  <= blink_on_r;
    end
  end

  assign shotActive = shot_active_r;
  assign shotDone   = shot_done_r;
  assign visible    = shot_active_r;
  assign blinkOn    = blink_on_r;

endmodule

// File: rtl/shot_bitmap_drawer.sv
// Shot sprite reader: two-stage geometry/colour pipeline producing a registered
// drawing request and RGB332 colour, gated by the shot life-cycle FSM.
module shot_bitmap_drawer
  import shot_pkg::*;
#(
  parameter int         FLASH_FRAMES = 16,
  parameter int         BLINK_FRAMES = 2,
  parameter logic [7:0] FLASH_COLOR  = 8'hFC
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic [10:0]  pixelX,
  input  logic [10:0]  pixelY,
  input  logic [10:0]  topLeftX,
  input  logic [10:0]  topLeftY,
  input  shot_bitmap_t object_colors,
  input  logic         fire,
  input  logic         hit,
  output logic         drawingRequest,
  output logic [7:0]   RGBout,
  output logic         shotActive,
  output logic         shotDone
);

  coord_t     dx_s, dy_s;
  logic       inside_r;
  logic [3:0] offx_r, offy_r;
  logic [7:0] pix_s;
  logic       draw_s, visible_s, blink_on_s;

  shot_flash_fsm #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fsm (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fire         (fire),
    .hit          (hit),
    .shotActive   (shotActive),
    .shotDone     (shotDone),
    .visible      (visible_s),
    .blinkOn      (blink_on_s)
  );

  // Scan position relative to the (signed) top-left corner, 12-bit signed.
  always_comb begin
    dx_s = coord_t'({1'b0, pixelX}) - coord_t'({topLeftX[10], topLeftX});
    dy_s = coord_t'({1'b0, pixelY}) - coord_t'({topLeftY[10], topLeftY});
  end

  // Stage 1: bounding-box test and bitmap offsets.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_r <= 1'b0;
      offx_r   <= 4'd0;
      offy_r   <= 4'd0;
    end else begin
      inside_r <= in_range(dx_s, coord_t'(OBJECT_WIDTH_X)) &&
                  in_range(dy_s, coord_t'(OBJECT_HEIGHT_Y));
      offx_r   <= dx_s[3:0];
      offy_r   <= dy_s[3:0];
    end
  end

  // Stage-2 lookup: opaque in-box pixels draw only while the shot is visible.
  always_comb begin
    pix_s  = object_colors[offy_r][offx_r];
    draw_s = inside_r && (pix_s != TRANSPARENT_COLOR) && visible_s;
  end

  // Stage 2: registered request and colour, flash colour on blink-on phases.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT_COLOR;
    end else begin
      drawingRequest <= draw_s;
      if (!draw_s)         RGBout <= TRANSPARENT_COLOR;
      else if (blink_on_s) RGBout <= FLASH_COLOR;
      else                 RGBout <= pix_s;
    end
  end

endmodule

// File: tb/tb_shot_bitmap_drawer.sv
// Scoreboard bench for shot_bitmap_drawer: stimulus queues expected pixel
// results two cycles ahead, a negedge monitor pops and compares them.
module tb_shot_bitmap_drawer;
  import shot_pkg::*;

  logic         clk = 1'b0;
  logic         resetN = 1'b1;
  logic         startOfFrame = 1'b0;
  logic [10:0]  pixelX = 11'd0, pixelY = 11'd0;
  logic [10:0]  topLeftX = 11'd100, topLeftY = 11'd50;
  shot_bitmap_t object_colors;
  logic         fire = 1'b0, hit = 1'b0;
  logic         drawingRequest, shotActive, shotDone;
  logic [7:0]   RGBout;

  shot_bitmap_drawer #(
    .FLASH_FRAMES (4),
    .BLINK_FRAMES (1),
    .FLASH_COLOR  (8'hFC)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .object_colors  (object_colors),
    .fire           (fire),
    .hit            (hit),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout),
    .shotActive     (shotActive),
    .shotDone       (shotDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       dr;
    logic [7:0] rgb;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count shotDone pulses and compare every due scoreboard entry.
  always @(negedge clk) begin
    if (shotDone) done_cnt++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e_mon = sbq.pop_front();
      checks++;
      if (e_mon.due != cyc || drawingRequest !== e_mon.dr || RGBout !== e_mon.rgb) begin
        failures++;
        $display("FAIL %s: cyc=%0d due=%0d got dr=%b rgb=%h expected dr=%b rgb=%h",
                 e_mon.name, cyc, e_mon.due, drawingRequest, RGBout, e_mon.dr, e_mon.rgb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [10:0] x, input logic [10:0] y,
                     input logic dr, input logic [7:0] rgb, input string name);
    step();
    pixelX = x;
    pixelY = y;
    sbq.push_back('{due: cyc + 2, dr: dr, rgb: rgb, name: name});
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic tick();
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  initial begin
    object_colors = '1;
    object_colors[8][8]   = 8'hE9;
    object_colors[0][6]   = 8'hF0;
    object_colors[3][6]   = 8'hFB;
    object_colors[15][15] = 8'h03;

    // Reset values
    #1 resetN = 1'b0;
    repeat (3) step();
    chk("reset_dr", {31'd0, drawingRequest}, 32'd0);
    chk("reset_rgb", {24'd0, RGBout}, 32'hFF);
    chk("reset_active", {31'd0, shotActive}, 32'd0);
    chk("reset_done", {31'd0, shotDone}, 32'd0);
    resetN = 1'b1;

    // IDLE: nothing drawn even over opaque pixels
    for (int i = 0; i < 16; i++)
      drv(11'(100 + i), 11'(50 + i), 1'b0, 8'hFF, "idle_sweep");
    drv(11'd108, 11'd58, 1'b0, 8'hFF, "idle_opaque");
    drain();

    // Launch
    step(); fire = 1'b1; step(); fire = 1'b0;
    chk("fly_active", {31'd0, shotActive}, 32'd1);
    drv(11'd108, 11'd58, 1'b1, 8'hE9, "fly_8_8");
    drv(11'd100, 11'd50, 1'b0, 8'hFF, "fly_transparent");
    drv(11'd106, 11'd50, 1'b1, 8'hF0, "fly_0_6");
    drv(11'd106, 11'd53, 1'b1, 8'hFB, "fly_3_6");
    drv(11'd115, 11'd65, 1'b1, 8'h03, "fly_15_15");
    drv(11'd116, 11'd65, 1'b0, 8'hFF, "fly_right_edge");
    drv(11'd115, 11'd66, 1'b0, 8'hFF, "fly_bottom_edge");
    drv(11'd99,  11'd58, 1'b0, 8'hFF, "fly_left_edge");
    drain();

    // Negative top-left (-8,-8)
    topLeftX = 11'h7F8; topLeftY = 11'h7F8;
    drv(11'd0, 11'd0, 1'b1, 8'hE9, "neg_0_0");
    drv(11'd7, 11'd7, 1'b1, 8'h03, "neg_7_7");
    drv(11'd8, 11'd8, 1'b0, 8'hFF, "neg_8_8");
    drain();
    topLeftX = 11'd100; topLeftY = 11'd50;

    // hit together with startOfFrame: that tick must not count
    step(); hit = 1'b1; startOfFrame = 1'b1; step(); hit = 1'b0; startOfFrame = 1'b0;
    drv(11'd108, 11'd58, 1'b1, 8'hFC, "flash0_blink");
    drv(11'd106, 11'd50, 1'b1, 8'hFC, "flash0_blink_b");
    drv(11'd100, 11'd50, 1'b0, 8'hFF, "flash0_transparent");
    drain();
    tick();
    drv(11'd108, 11'd58, 1'b1, 8'hE9, "flash1_pix");
    drain();
    tick();
    drv(11'd108, 11'd58, 1'b1, 8'hFC, "flash2_blink");
    drain();
    tick();
    drv(11'd108, 11'd58, 1'b1, 8'hE9, "flash3_pix");
    drain();
    chk("flash3_no_done", done_cnt, 32'd0);
    chk("flash3_active", {31'd0, shotActive}, 32'd1);
    tick();
    drain();
    chk("done_once", done_cnt, 32'd1);
    chk("after_done_active", {31'd0, shotActive}, 32'd0);
    drv(11'd108, 11'd58, 1'b0, 8'hFF, "after_done_idle");
    drain();

    // hit in IDLE ignored
    step(); hit = 1'b1; step(); hit = 1'b0;
    step();
    chk("idle_hit_ignored", {31'd0, shotActive}, 32'd0);

    // fire+hit in IDLE -> FLY only
    step(); fire = 1'b1; hit = 1'b1; step(); fire = 1'b0; hit = 1'b0;
    drv(11'd108, 11'd58, 1'b1, 8'hE9, "firehit_fly");
    drain();
    repeat (5) tick();
    drv(11'd108, 11'd58, 1'b1, 8'hE9, "firehit_still_fly");
    drain();
    chk("firehit_no_done", done_cnt, 32'd1);
    chk("firehit_active", {31'd0, shotActive}, 32'd1);

    // Enter FLASH, then reset in the middle of it
    step(); hit = 1'b1; step(); hit = 1'b0;
    drv(11'd108, 11'd58, 1'b1, 8'hFC, "flash_b0");
    drain();
    tick();
    drv(11'd108, 11'd58, 1'b1, 8'hE9, "flash_b1");
    drain();
    step();
    resetN = 1'b0;
    #1;
    chk("midreset_dr", {31'd0, drawingRequest}, 32'd0);
    chk("midreset_rgb", {24'd0, RGBout}, 32'hFF);
    chk("midreset_active", {31'd0, shotActive}, 32'd0);
    chk("midreset_done", {31'd0, shotDone}, 32'd0);
    repeat (3) step();
    resetN = 1'b1;
    repeat (3) step();
    chk("midreset_no_pulse", done_cnt, 32'd1);
    drv(11'd108, 11'd58, 1'b0, 8'hFF, "post_reset_idle");
    drain();

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
